// File: rtl/fifo_tx_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pkg
// Purpose  : Shared types and defaults for the FIFO and its serial drain stage.
// Revision : 1.0  initial release
// ============================================================================

package fifo_pkg;

    localparam int WIDTH = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POP   = 3'd1,
        CAP   = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } tx_state_t;

    // Counter width for a 0..cycles-1 timer; never narrower than one bit.
    function automatic int timer_bits(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_tx_serializer_bit_timer.sv
`default_nettype none
// ============================================================================
// Module   : bit_timer
// Purpose  : Free-running 0..clks_per_bit-1 counter with a last-count tick.
// Revision : 1.0  initial release
// ============================================================================

module bit_timer
    import fifo_pkg::*;
#(
    parameter int clks_per_bit = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = timer_bits(clks_per_bit);
    localparam logic [CW-1:0] LAST = CW'(clks_per_bit - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

`default_nettype wire

// File: rtl/fifo_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : fifo_tx_serializer
// Purpose  : Pops FIFO words and sends them as start/data(LSB first)/stop frames.
// Revision : 1.0  initial release
// ============================================================================

module fifo_tx_serializer
    import fifo_pkg::*;
#(
    parameter int width        = WIDTH,
    parameter int clks_per_bit = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             empty,
    input  logic [width-1:0] fifo_out,
    output logic             pop,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    localparam int            BW       = $clog2(width + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(width - 1);

    tx_state_t        state;
    tx_state_t        state_next;
    logic [width-1:0] shreg;
    logic [width-1:0] shreg_next;
    logic [BW-1:0]    bit_cnt;
    logic [BW-1:0]    bit_cnt_next;
    logic             tx_reg;
    logic             tx_next;
    logic             tick;
    logic             timer_clear;

    bit_timer #(
        .clks_per_bit (clks_per_bit)
    ) u_bit_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (timer_clear),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        pop         = 1'b0;
        busy        = (state != IDLE);
        done        = 1'b0;
        // The timer only runs while a bit is on the line; CAP leaves it at zero.
        timer_clear = 1'b1;
        case (state)
            IDLE: begin
                if (en && !empty) begin
                    state_next = POP;
                end
            end
            POP: begin
                pop        = 1'b1;
                state_next = CAP;
            end
            CAP: begin
                state_next = START;
            end
            START: begin
                timer_clear = 1'b0;
                if (tick) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                timer_clear = 1'b0;
                if (tick && (bit_cnt == LAST_BIT)) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                timer_clear = 1'b0;
                done        = tick;
                if (tick) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        shreg_next   = shreg;
        bit_cnt_next = bit_cnt;
        tx_next      = 1'b1;
        case (state)
            CAP: begin
                shreg_next   = fifo_out;
                bit_cnt_next = '0;
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_next = '0;
                    end else begin
                        bit_cnt_next = bit_cnt + BW'(1);
                        shreg_next   = shreg >> 1;
                    end
                end
            end
            default: begin
            end
        endcase
        // tx is registered, so it is computed from where the FSM is heading.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shreg_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
            tx_reg  <= 1'b1;
        end else begin
            shreg   <= shreg_next;
            bit_cnt <= bit_cnt_next;
            tx_reg  <= tx_next;
        end
    end

    assign tx = tx_reg;

endmodule

`default_nettype wire

// File: tb/tb_fifo_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_tx_serializer
// Purpose  : Directed self-checking bench with a FIFO model and a serial receiver.
// Revision : 1.0  initial release
// ============================================================================

module tb_fifo_tx_serializer;

    localparam int CPB = 4;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       en       = 1'b1;
    logic       empty    = 1'b0;
    logic [3:0] fifo_out = 4'h0;
    logic       pop;
    logic       tx;
    logic       busy;
    logic       done;

    int n_vec = 0;
    int n_err = 0;

    logic [3:0] fifo_q[$];
    int         pop_times[$];
    int         done_times[$];
    logic [3:0] rx_words[$];
    int         underflows     = 0;
    int         stop_errs      = 0;
    int         cyc            = 0;
    bit         force_nonempty = 1'b1;
    logic       prev_tx        = 1'b1;
    bit         rx_active      = 1'b0;
    int         rx_cnt         = 0;
    logic [3:0] rx_shift       = 4'h0;
    logic [5:0] pat;

    fifo_tx_serializer dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .empty    (empty),
        .fifo_out (fifo_out),
        .pop      (pop),
        .tx       (tx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // FIFO read-port model, event log and mid-bit serial receiver.
    always @(negedge clk) begin
        if (pop) begin
            pop_times.push_back(cyc);
            if (fifo_q.size() > 0) fifo_out = fifo_q.pop_front();
            else underflows++;
        end
        if (done) done_times.push_back(cyc);
        empty = force_nonempty ? 1'b0 : (fifo_q.size() == 0);
        if (rst) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (prev_tx && !tx) begin
                rx_active = 1'b1;
                rx_cnt    = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt >= CPB && rx_cnt < 5*CPB && (rx_cnt % CPB) == CPB/2)
                rx_shift = {tx, rx_shift[3:1]};
            if (rx_cnt == 5*CPB + CPB/2) begin
                if (tx !== 1'b1) stop_errs++;
                rx_words.push_back(rx_shift);
                rx_active = 1'b0;
            end
        end
        prev_tx = tx;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        pop_times.delete();
        done_times.delete();
        rx_words.delete();
    endtask

    task automatic wait_pops(input int n, input int budget, input string tag);
        int k = 0;
        while (pop_times.size() < n && k < budget) begin
            step();
            k++;
        end
        check(tag, 32'(pop_times.size() >= n), 32'd1);
    endtask

    task automatic wait_dones(input int n, input int budget, input string tag);
        int k = 0;
        while (done_times.size() < n && k < budget) begin
            step();
            k++;
        end
        check(tag, 32'(done_times.size() >= n), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with a pending word must keep every output quiet.
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_outputs", {28'd0, tx, pop, busy, done}, 32'b1000);
        end
        rst            = 1'b0;
        en             = 1'b0;
        force_nonempty = 1'b0;
        repeat (3) step();
        check("rst_release_idle", {30'd0, tx, busy}, 32'b10);

        // Single word 4'hA.
        clear_logs();
        fifo_q.push_back(4'hA);
        en = 1'b1;
        wait_pops(1, 10, "t2_pop_seen");
        check("t2_pop_level", 32'(pop), 32'd1);
        pat = 6'b110100;
        repeat (2) step();
        for (int i = 0; i < 24; i++) begin
            check("t2_tx_done", {30'd0, tx, done}, {30'd0, pat[i/4], 1'(i == 23)});
            step();
        end
        check("t2_busy_low", {30'd0, busy, tx}, 32'b01);
        check("t2_done_latency",
              (done_times.size() > 0 && pop_times.size() > 0) ? 32'(done_times[0] - pop_times[0]) : 32'hFFFF, 32'd25);
        repeat (5) step();
        check("t2_pop_count", 32'(pop_times.size()), 32'd1);

        // Back-to-back drain of 1..5.
        clear_logs();
        for (int k = 1; k <= 5; k++) fifo_q.push_back(4'(k));
        wait_dones(5, 200, "t3_all_done");
        repeat (20) step();
        check("t3_pop_count", 32'(pop_times.size()), 32'd5);
        for (int k = 1; k < 5; k++)
            check("t3_pop_gap", (pop_times.size() > k) ? 32'(pop_times[k] - pop_times[k-1]) : 32'hFFFF, 32'd27);
        for (int k = 0; k < 5; k++)
            check("t3_payload", (rx_words.size() > k) ? 32'(rx_words[k]) : 32'hFFFF, 32'(k + 1));

        // Idle on empty.
        for (int i = 0; i < 50; i++) begin
            step();
            check("t4_idle_empty", {29'd0, pop, tx, busy}, 32'b010);
        end

        // Enable dropped during the data bits of word 3.
        clear_logs();
        for (int k = 10; k <= 15; k++) fifo_q.push_back(4'(k));
        wait_pops(3, 100, "t5_third_pop");
        repeat (10) step();
        check("t5_in_frame", 32'(busy), 32'd1);
        en = 1'b0;
        wait_dones(3, 60, "t5_third_done");
        repeat (40) step();
        check("t5_pop_count", 32'(pop_times.size()), 32'd3);
        check("t5_done_count", 32'(done_times.size()), 32'd3);
        check("t5_left_in_fifo", 32'(fifo_q.size()), 32'd3);
        for (int k = 0; k < 3; k++)
            check("t5_payload", (rx_words.size() > k) ? 32'(rx_words[k]) : 32'hFFFF, 32'(10 + k));
        fifo_q.delete();
        repeat (2) step();

        // Reset in the middle of a frame, then a clean restart.
        clear_logs();
        fifo_q.push_back(4'h5);
        fifo_q.push_back(4'h6);
        en = 1'b1;
        wait_pops(1, 10, "t6_first_pop");
        repeat (10) step();
        rst = 1'b1;
        step();
        check("t6_abort", {29'd0, tx, busy, pop}, 32'b100);
        rst = 1'b0;
        rx_words.delete();
        step();
        check("t6_restart_pop", 32'(pop), 32'd1);
        step();
        check("t6_cap_tx", 32'(tx), 32'd1);
        for (int j = 0; j < CPB; j++) begin
            step();
            check("t6_start_bit", {30'd0, tx, busy}, 32'b01);
        end
        wait_dones(1, 40, "t6_done");
        repeat (5) step();
        check("t6_rx_count", 32'(rx_words.size()), 32'd1);
        check("t6_payload", (rx_words.size() > 0) ? 32'(rx_words[0]) : 32'hFFFF, 32'h6);

        check("stop_bits", 32'(stop_errs), 32'd0);
        check("underflows", 32'(underflows), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
